// File: rtl/rfid_token_filter.sv
// rtl/rfid_token_filter.sv - ESP32 token framer with replay detection against a circular accepted-token history
// Optional build macro: TOKEN_NULL_REJECT_EN (reject all-0s / all-1s tokens with frame_err).
module rfid_token_filter #(
    parameter int TOKEN_BYTES = 8,
    parameter int HIST_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic [7:0]               bus_data,
    input  logic                     bus_clk,
    input  logic                     bus_latch,
    output logic                     valid_out,
    output logic                     replay_out,
    output logic                     frame_err,
    output logic [8*TOKEN_BYTES-1:0] token_out,
    output logic                     busy
);

    localparam int TW  = 8 * TOKEN_BYTES;
    localparam int CW  = $clog2(TOKEN_BYTES + 1);
    localparam int IW  = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam int TMW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0]  LAST_BYTE   = CW'(TOKEN_BYTES - 1);
    localparam logic [IW-1:0]  LAST_IDX    = IW'(HIST_DEPTH - 1);
    localparam logic [TMW-1:0] TIMEOUT_VAL = TMW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RECV    = 2'd1,
        S_COMPARE = 2'd2,
        S_REPORT  = 2'd3
    } state_t;

    state_t state, state_n;

    // Two flops of synchronisation plus one for edge detection, per strobe
    logic [2:0] clk_sync;
    logic [2:0] latch_sync;
    logic       strobe;
    logic       latch_rise;

    logic [TW-1:0]  shreg;
    logic [TW-1:0]  shreg_next;
    logic [CW-1:0]  byte_cnt, byte_cnt_n;
    logic [TMW-1:0] timer, timer_n;
    logic [IW-1:0]  idx, idx_n;
    logic           hit, hit_n;
    logic           null_q, null_n;

    logic [TW-1:0]         hist [HIST_DEPTH];
    logic [HIST_DEPTH-1:0] hist_valid;
    logic [IW-1:0]         wr_ptr;
    logic                  entry_match;

    logic shift_en;
    logic tok_load;
    logic hist_we;
    logic valid_n, replay_n, ferr_n;

    // Synchronise the asynchronous ESP32 strobes into the CLOCK_50 domain
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_sync   <= 3'b000;
            latch_sync <= 3'b000;
        end else begin
            clk_sync   <= {clk_sync[1:0], bus_clk};
            latch_sync <= {latch_sync[1:0], bus_latch};
        end
    end

    assign strobe     = clk_sync[1] & ~clk_sync[2];
    assign latch_rise = latch_sync[1] & ~latch_sync[2];

    // MSB-first byte shifting; a single-byte token simply takes the new byte
    generate
        if (TOKEN_BYTES == 1) begin : gen_shift_one
            assign shreg_next = bus_data;
        end else begin : gen_shift_multi
            assign shreg_next = {shreg[TW-9:0], bus_data};
        end
    endgenerate

    assign entry_match = hist_valid[idx] && (hist[idx] == shreg);

`ifdef TOKEN_NULL_REJECT_EN
    logic shreg_next_null;
    assign shreg_next_null = (shreg_next == '0) || (shreg_next == '1);
`endif

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and next-output decode; latch beats strobe beats timeout in RECV
    always_comb begin
        state_n    = state;
        byte_cnt_n = byte_cnt;
        timer_n    = timer;
        idx_n      = idx;
        hit_n      = hit;
        null_n     = null_q;
        shift_en   = 1'b0;
        tok_load   = 1'b0;
        hist_we    = 1'b0;
        valid_n    = 1'b0;
        replay_n   = 1'b0;
        ferr_n     = 1'b0;

        case (state)
            S_IDLE: begin
                if (latch_rise) begin
                    state_n    = S_RECV;
                    byte_cnt_n = '0;
                    timer_n    = '0;
                    hit_n      = 1'b0;
                    null_n     = 1'b0;
                end
            end

            S_RECV: begin
                if (latch_rise) begin
                    byte_cnt_n = '0;
                    timer_n    = '0;
                    ferr_n     = 1'b1;
                end else if (strobe) begin
                    shift_en = 1'b1;
                    timer_n  = '0;
                    if (byte_cnt == LAST_BYTE) begin
                        byte_cnt_n = '0;
                        idx_n      = '0;
                        hit_n      = 1'b0;
`ifdef TOKEN_NULL_REJECT_EN
                        if (shreg_next_null) begin
                            null_n  = 1'b1;
                            state_n = S_REPORT;
                        end else begin
                            state_n = S_COMPARE;
                        end
`else
                        state_n = S_COMPARE;
`endif
                    end else begin
                        byte_cnt_n = byte_cnt + 1'b1;
                    end
                end else if (timer == TIMEOUT_VAL) begin
                    ferr_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end

            S_COMPARE: begin
                if (entry_match) begin
                    hit_n   = 1'b1;
                    state_n = S_REPORT;
                end else if (idx == LAST_IDX) begin
                    state_n = S_REPORT;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end

            S_REPORT: begin
                tok_load = 1'b1;
                state_n  = S_IDLE;
                if (null_q) begin
                    ferr_n = 1'b1;
                end else if (hit) begin
                    replay_n = 1'b1;
                end else begin
                    valid_n = 1'b1;
                    hist_we = 1'b1;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Datapath registers, result pulses and history bookkeeping
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            byte_cnt   <= '0;
            timer      <= '0;
            idx        <= '0;
            hit        <= 1'b0;
            null_q     <= 1'b0;
            shreg      <= '0;
            token_out  <= '0;
            valid_out  <= 1'b0;
            replay_out <= 1'b0;
            frame_err  <= 1'b0;
            hist_valid <= '0;
            wr_ptr     <= '0;
        end else begin
            byte_cnt   <= byte_cnt_n;
            timer      <= timer_n;
            idx        <= idx_n;
            hit        <= hit_n;
            null_q     <= null_n;
            valid_out  <= valid_n;
            replay_out <= replay_n;
            frame_err  <= ferr_n;
            if (shift_en) begin
                shreg <= shreg_next;
            end
            if (tok_load) begin
                token_out <= shreg;
            end
            if (hist_we) begin
                hist_valid[wr_ptr] <= 1'b1;
                wr_ptr             <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
            end
        end
    end

    // History payload; validity bits alone mark live entries, so no reset needed
    always_ff @(posedge CLOCK_50) begin
        if (hist_we) begin
            hist[wr_ptr] <= shreg;
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_rfid_token_filter.sv
// tb/tb_rfid_token_filter.sv - randomized self-checking bench for rfid_token_filter
module tb_rfid_token_filter;

    localparam int TB = 8;
    localparam int HD = 4;
    localparam int TO = 64;
    localparam int TW = 8 * TB;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    bus_data;
    logic          bus_clk;
    logic          bus_latch;
    logic          valid_out;
    logic          replay_out;
    logic          frame_err;
    logic [TW-1:0] token_out;
    logic          busy;

    rfid_token_filter #(
        .TOKEN_BYTES(TB),
        .HIST_DEPTH (HD),
        .TIMEOUT_CYC(TO)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .bus_data  (bus_data),
        .bus_clk   (bus_clk),
        .bus_latch (bus_latch),
        .valid_out (valid_out),
        .replay_out(replay_out),
        .frame_err (frame_err),
        .token_out (token_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_replay = 0;
    int n_ferr = 0;
    int last_pulse_cyc = 0;
    bit prev_pulse = 1'b0;

    // Reference model: accepted tokens fill slots in arrival order, wrapping
    logic [TW-1:0] m_hist [HD];
    bit            m_val  [HD];
    int            m_wr;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts results, checks exclusivity and single-cycle width
    always @(negedge clk) begin
        int n_hi;
        n_hi = int'(valid_out) + int'(replay_out) + int'(frame_err);
        if (valid_out)  n_valid++;
        if (replay_out) n_replay++;
        if (frame_err)  n_ferr++;
        if (n_hi > 0) begin
            last_pulse_cyc = cyc;
            checks++;
            if (n_hi > 1) begin
                errors++;
                $display("FAIL pulse_exclusive: %0d pulses high, required at most 1", n_hi);
            end
            checks++;
            if (prev_pulse) begin
                errors++;
                $display("FAIL pulse_width: pulse high on consecutive cycles, required 1 cycle");
            end
        end
        prev_pulse = (n_hi > 0);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < HD; i++) begin
            m_val[i]  = 1'b0;
            m_hist[i] = '0;
        end
        m_wr = 0;
    endtask

    // kind: 0 accepted, 1 replay, 2 rejected; lat: cycles from final byte shift to pulse
    task automatic model_token(input logic [TW-1:0] tok, output int kind, output int lat);
        int hit_k;
        hit_k = -1;
`ifdef TOKEN_NULL_REJECT_EN
        if (tok == {TW{1'b0}} || tok == {TW{1'b1}}) begin
            kind = 2;
            lat  = 1;
            return;
        end
`endif
        for (int k = 0; k < HD; k++) begin
            if (hit_k < 0 && m_val[k] && m_hist[k] == tok) hit_k = k;
        end
        if (hit_k >= 0) begin
            kind = 1;
            lat  = hit_k + 2;
        end else begin
            kind = 0;
            lat  = HD + 1;
            m_hist[m_wr] = tok;
            m_val[m_wr]  = 1'b1;
            m_wr = (m_wr + 1) % HD;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bus_clk   = 1'b0;
        bus_latch = 1'b0;
        bus_data  = 8'h00;
        tick(3);
        reset = 1'b0;
        tick(2);
        model_clear();
    endtask

    task automatic latch_pulse();
        bus_latch = 1'b1;
        tick(4);
        bus_latch = 1'b0;
        tick(4);
    endtask

    task automatic send_byte(input logic [7:0] b, output int rise_cyc);
        bus_data = b;
        bus_clk  = 1'b1;
        rise_cyc = cyc;
        tick(4);
        bus_clk = 1'b0;
        tick($urandom_range(3, 5));
    endtask

    task automatic send_checked(input logic [TW-1:0] tok, input int pre_ferr, input string name);
        int v0, r0, f0, rc, kind, lat;
        v0 = n_valid;
        r0 = n_replay;
        f0 = n_ferr;
        latch_pulse();
        for (int i = 0; i < TB; i++) send_byte(tok[TW-1-8*i -: 8], rc);
        model_token(tok, kind, lat);
        tick(HD + 8);
        checks++;
        if ((n_valid - v0) !== ((kind == 0) ? 1 : 0)) begin
            errors++;
            $display("FAIL %s valid_out count: got %0d required %0d", name, n_valid - v0, (kind == 0) ? 1 : 0);
        end
        checks++;
        if ((n_replay - r0) !== ((kind == 1) ? 1 : 0)) begin
            errors++;
            $display("FAIL %s replay_out count: got %0d required %0d", name, n_replay - r0, (kind == 1) ? 1 : 0);
        end
        checks++;
        if ((n_ferr - f0) !== (pre_ferr + ((kind == 2) ? 1 : 0))) begin
            errors++;
            $display("FAIL %s frame_err count: got %0d required %0d", name, n_ferr - f0, pre_ferr + ((kind == 2) ? 1 : 0));
        end
        checks++;
        if (token_out !== tok) begin
            errors++;
            $display("FAIL %s token_out: got %h required %h", name, token_out, tok);
        end
        checks++;
        if (last_pulse_cyc !== rc + 3 + lat) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", name, last_pulse_cyc - rc, 3 + lat);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy after result: got %b required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus_clk   = 1'b0;
        bus_latch = 1'b0;
        bus_data  = 8'h00;
        tick(3);
        checks++;
        if ({valid_out, replay_out, frame_err, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0000", {valid_out, replay_out, frame_err, busy});
        end
        checks++;
        if (token_out !== '0) begin
            errors++;
            $display("FAIL reset_token: got %h required 0", token_out);
        end
        reset = 1'b0;
        tick(2);
        model_clear();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_after: got %b required 0", busy);
        end
    endtask

    task automatic test_basic();
        send_checked(64'h0102030405060708, 0, "basic_accept");
        send_checked(64'h0102030405060708, 0, "basic_replay");
    endtask

    task automatic test_history_wrap();
        logic [TW-1:0] toks [5];
        do_reset();
        for (int i = 0; i < 5; i++) toks[i] = {$urandom, $urandom} | 64'h1;
        toks[1][63:56] = 8'hB0;
        toks[0][63:56] = 8'hA0;
        toks[2][63:56] = 8'hC0;
        toks[3][63:56] = 8'hD0;
        toks[4][63:56] = 8'hE0;
        for (int i = 0; i < 5; i++) send_checked(toks[i], 0, "wrap_fill");
        send_checked(toks[0], 0, "wrap_overwritten_a");
        send_checked(toks[4], 0, "wrap_replay_e");
    endtask

    task automatic test_timeout();
        int v0, r0, f0, rc;
        v0 = n_valid;
        r0 = n_replay;
        f0 = n_ferr;
        latch_pulse();
        for (int i = 0; i < 3; i++) send_byte(8'h30 + 8'(i), rc);
        tick(20);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_busy_before: got %b required 1", busy);
        end
        tick(TO + 10);
        checks++;
        if ((n_ferr - f0) !== 1) begin
            errors++;
            $display("FAIL timeout_frame_err: got %0d required 1", n_ferr - f0);
        end
        checks++;
        if ((n_valid - v0) + (n_replay - r0) !== 0) begin
            errors++;
            $display("FAIL timeout_no_result: got %0d required 0", (n_valid - v0) + (n_replay - r0));
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_busy_after: got %b required 0", busy);
        end
    endtask

    task automatic test_restart();
        int rc;
        latch_pulse();
        for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i), rc);
        send_checked(64'h1112131415161718, 1, "restart");
    endtask

    task automatic test_idle_strobes();
        int v0, r0, f0, rc;
        v0 = n_valid;
        r0 = n_replay;
        f0 = n_ferr;
        for (int i = 0; i < 3; i++) send_byte(8'(($urandom)), rc);
        tick(4);
        checks++;
        if ((n_valid - v0) + (n_replay - r0) + (n_ferr - f0) !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_strobes: got %0d pulses busy=%b required 0 pulses busy=0",
                     (n_valid - v0) + (n_replay - r0) + (n_ferr - f0), busy);
        end
    endtask

    task automatic test_null();
        send_checked({TW{1'b1}}, 0, "null_ones_first");
        send_checked({TW{1'b1}}, 0, "null_ones_second");
        send_checked({TW{1'b0}}, 0, "null_zeros");
    endtask

    task automatic test_random();
        logic [TW-1:0] pool [6];
        do_reset();
        for (int i = 0; i < 6; i++) pool[i] = {$urandom, $urandom};
        for (int n = 0; n < 24; n++) begin
            send_checked(pool[$urandom_range(0, 5)], 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_history_wrap();
        test_timeout();
        test_restart();
        test_idle_strobes();
        test_null();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rfid_token_filter.md
# rfid_token_filter

Parametrised successor to the single-entry token checker. It sits between the ESP32 byte bus and the door/actuator logic. It runs entirely on CLOCK_50, synchronises the ESP32 strobes, frames tokens of TOKEN_BYTES bytes using bus_latch, and checks each completed token against a circular history of the last HIST_DEPTH accepted tokens. Results are reported as single-cycle pulses, and an inter-byte timeout with framing-error reporting is included.

## Interface
- TOKEN_BYTES, 8: bytes per token, ≥1; token width TW = 8*TOKEN_BYTES
- HIST_DEPTH, 4: accepted-token history entries, ≥1
- TIMEOUT_CYC, 50000: max CLOCK_50 cycles between strobes inside a frame, ≥8
- CLOCK_50  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- bus_data  in  8  byte from ESP32, held stable ≥4 cycles after bus_clk rises
- bus_clk  in  1  asynchronous byte strobe; a byte is taken on its rising edge
- bus_latch  in  1  asynchronous frame marker; its rising edge starts a frame
- valid_out  out  1  one-cycle pulse: new token accepted
- replay_out  out  1  one-cycle pulse: token matches history
- frame_err  out  1  one-cycle pulse: timeout, short or rejected frame
- token_out  out  TW  last completed token; updated together with any result pulse
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Synchronisers: bus_clk and bus_latch each pass through 2 flops, then a third flop for edge detection. bus_data is sampled on the cycle the synchronised bus_clk rising edge is detected.
- Byte order is MSB-first: shift register ← {shreg[TW-9:0], bus_data}.
- State IDLE: a latch rise clears byte_cnt, clears the timer and moves to RECV. Strobes received in IDLE are ignored.
- State RECV:
  - Each strobe shifts in one byte, increments byte_cnt and clears the timer.
  - When byte_cnt reaches TOKEN_BYTES, the state moves to COMPARE with idx=0.
  - A latch rise while in RECV restarts the frame: byte_cnt=0, frame_err pulses once.
  - If the timer reaches TIMEOUT_CYC: frame_err pulses and the state returns to IDLE.
  - If a strobe and a latch rise occur in the same cycle, the latch wins and the strobe is dropped.
- State COMPARE:
  - One history entry is checked per cycle, idx = 0..HIST_DEPTH-1. An entry matches when valid[idx] is set and hist[idx]==shreg.
  - On the first match: set the hit flag, then go to REPORT.
  - After the last idx with no match, go to REPORT.
  - Strobes and latch edges are ignored in this state.
- State REPORT, lasting 1 cycle:
  - token_out ← shreg.
  - On a hit, replay_out pulses.
  - On no hit, valid_out pulses, hist[wr_ptr] ← shreg, valid[wr_ptr] ← 1, and wr_ptr advances, wrapping from HIST_DEPTH-1 to 0. When the history is full, the oldest entry is overwritten.
  - A replay does not modify the history.
  - The state then returns to IDLE.
- At most one of valid_out, replay_out and frame_err is high in any cycle.

## Timing
- Reset values: valid_out=0, replay_out=0, frame_err=0, token_out=0, busy=0, state=IDLE, all valid[] bits=0, wr_ptr=0, byte_cnt=0, timer=0, synchroniser flops=0.
- Strobe latency: 3 cycles from a bus_clk rise to the byte being shifted in.
- Result latency: from the cycle the final byte is shifted in to the result pulse, the delay is k+2 cycles for a hit at index k, and HIST_DEPTH+1 cycles for no hit.
- Minimum strobe spacing is 4 CLOCK_50 cycles. Each half-period of bus_clk and bus_latch must be ≥3 cycles.
- A reset asserted mid-frame or mid-compare aborts the operation with no pulse. The history is cleared by reset.
- Pulses are exactly 1 CLOCK_50 cycle wide.

## Configuration
- `TOKEN_NULL_REJECT_EN` defined:
  - A completed token that is all-0s or all-1s skips COMPARE.
  - In the next cycle: frame_err pulses, token_out updates, the history is unchanged, and the state returns to IDLE.
- Not defined: null tokens are processed like any other token.

## Test plan
- Reset, latch rise, bytes 01..08 → valid_out pulse; token_out=64'h0102030405060708; wr_ptr=1.
- Send the same token again → replay_out pulse, valid_out stays 0, wr_ptr stays 1.
- With HIST_DEPTH=4, send tokens A, B, C, D, E, then A → six valid_out pulses, because A was overwritten by E. Then send E → replay_out.
- Latch rise, 3 bytes, then idle for TIMEOUT_CYC cycles → one frame_err pulse, busy falls, no valid_out or replay_out.
- Latch rise, 5 bytes, latch rise, 8 bytes 11..18 → one frame_err pulse, then valid_out with token_out=64'h1112131415161718.
- With `TOKEN_NULL_REJECT_EN` defined, send 8×8'hFF → frame_err pulse and the history is unchanged. Without it → valid_out pulse.
